uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing of an asynchronous serial line oversampled in the
// hwclk domain, delivering bytes on a valid/ready output with framing and
// overrun status.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rx_m;
    logic               r_rx_s;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_ferr;
    logic               r_ovr;

    logic               w_half;
    logic               w_full;
    logic               w_cnt_clr;
    logic               w_shift;
    logic               w_load;
    logic               w_ferr;
    logic               w_xfer;

    // Counter is cleared on entry to START, so in START it lags the frame
    // cycle number by one: terminal count HALF_BIT-1 lands on cycle HALF_BIT.
    assign w_half = (r_cnt == CNT_W'(HALF_BIT - 1));
    assign w_full = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_xfer = r_valid & rx_ready;

    // Two-flop synchronizer; idles high so reset cannot fake a start edge.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    // State register.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes; every sample point also clears the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_full) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit-time cycle counter; only runs while timing a bit.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Data bit index; returns to 0 after bit 7 so the next frame starts clean.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_bit <= 3'd0;
        end else if (w_shift) begin
            r_bit <= (r_bit == 3'd7) ? 3'd0 : r_bit + 3'd1;
        end
    end

    // LSB-first shift register: each sample enters at the MSB.
    always_ff @(posedge hwclk) begin
        if (w_shift) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    // Output byte, valid/ready handshake, framing pulse and sticky overrun.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_load && r_valid && !w_xfer) begin
                r_ovr <= 1'b1;
            end else if (w_xfer && !w_load) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign framing_err = r_ferr;
    assign overrun     = r_ovr;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       hwclk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    int         cyc = 0;
    logic       prev_valid = 1'b0;
    int         rise_cnt = 0;
    logic [7:0] rise_log [0:63];
    int         rise_cyc [0:63];
    int         ferr_cnt = 0;
    int         ferr_run = 0;
    int         ferr_max = 0;
    int         ovr_cyc  = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .hwclk       (hwclk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 hwclk = ~hwclk;

    // Cycle stamp, advanced on every rising edge.
    always @(posedge hwclk) cyc <= cyc + 1;

    // Event monitor: valid rising edges with their byte, framing pulses, overrun cycles.
    always @(negedge hwclk) begin
        prev_valid <= rx_valid;
        if (rx_valid && !prev_valid) begin
            rise_log[rise_cnt] <= rx_data;
            rise_cyc[rise_cnt] <= cyc;
            rise_cnt           <= rise_cnt + 1;
        end
        if (framing_err) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_run <= ferr_run + 1;
            if (ferr_run + 1 > ferr_max) ferr_max <= ferr_run + 1;
        end else begin
            ferr_run <= 0;
        end
        if (overrun) ovr_cyc <= ovr_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic sample();
        @(negedge hwclk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge hwclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base_f;
        int base_o;
        int t0;

        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        sample();
        chk("rst_data",  rx_data,     8'h00);
        chk("rst_valid", rx_valid,    1'b0);
        chk("rst_ferr",  framing_err, 1'b0);
        chk("rst_ovr",   overrun,     1'b0);
        chk("rst_busy",  busy,        1'b0);
        idle(4);

        // Frame 0x55, latency = 2 sync cycles + 4 + 72 + 1.
        base = rise_cnt;
        t0   = cyc;
        send_frame(8'h55, 1'b1);
        idle(4);
        sample();
        chk("f55_rises", rise_cnt - base, 1);
        chk("f55_lat",   rise_cyc[base] - t0, 79);
        chk("f55_data",  rx_data,     8'h55);
        chk("f55_valid", rx_valid,    1'b1);
        chk("f55_ferr",  ferr_cnt,    0);
        chk("f55_ovr",   overrun,     1'b0);
        idle(1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        sample();
        chk("f55_taken", rx_valid, 1'b0);
        idle(4);

        // Glitch of 3 cycles: false start, back to IDLE by frame cycle 5.
        base   = rise_cnt;
        base_f = ferr_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        @(negedge hwclk);
        chk("gl_busy_c1", busy, 1'b1);
        repeat (4) @(posedge hwclk);
        @(negedge hwclk);
        chk("gl_busy_c5", busy, 1'b0);
        idle(10);
        chk("gl_rises", rise_cnt - base, 0);
        chk("gl_ferr",  ferr_cnt - base_f, 0);
        send_frame(8'hA5, 1'b1);
        idle(4);
        sample();
        chk("a5_rises", rise_cnt - base, 1);
        chk("a5_byte",  rise_log[base], 8'hA5);
        idle(1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(4);

        // Framing error: 0xA3 with low stop bit, line held low (break).
        base   = rise_cnt;
        base_f = ferr_cnt;
        send_frame(8'hA3, 1'b0);
        idle(20);
        sample();
        chk("fe_pulses", ferr_cnt - base_f, 1);
        chk("fe_width",  ferr_max, 1);
        chk("fe_rises",  rise_cnt - base, 0);
        chk("fe_valid",  rx_valid, 1'b0);
        chk("fe_busy",   busy, 1'b1);
        idle(1);
        rx = 1'b1;
        idle(5);
        sample();
        chk("fe_idle", busy, 1'b0);
        idle(4);

        // Overrun: two bytes with no consumer.
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(4);
        sample();
        chk("ov_data",  rx_data,  8'h34);
        chk("ov_valid", rx_valid, 1'b1);
        chk("ov_set",   overrun,  1'b1);
        idle(1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        sample();
        chk("ov_vclr", rx_valid, 1'b0);
        chk("ov_oclr", overrun,  1'b0);
        idle(4);

        // Back-to-back frames with the consumer always ready.
        base   = rise_cnt;
        base_o = ovr_cyc;
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(5);
        rx_ready = 1'b0;
        sample();
        chk("bb_rises", rise_cnt - base, 3);
        chk("bb_b0",    rise_log[base],     8'h00);
        chk("bb_b1",    rise_log[base + 1], 8'hFF);
        chk("bb_b2",    rise_log[base + 2], 8'h81);
        chk("bb_ovr",   ovr_cyc - base_o, 0);
        idle(4);

        // Load valid+overrun, then reset during data bit 4 of 0x3C.
        send_frame(8'h5A, 1'b1);
        send_frame(8'h66, 1'b1);
        idle(2);
        sample();
        chk("pre_ovr", overrun, 1'b1);
        idle(1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        idle(3);
        @(negedge hwclk);
        chk("mid_busy", busy, 1'b1);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        sample();
        chk("mr_data",  rx_data,     8'h00);
        chk("mr_valid", rx_valid,    1'b0);
        chk("mr_ferr",  framing_err, 1'b0);
        chk("mr_ovr",   overrun,     1'b0);
        chk("mr_busy",  busy,        1'b0);
        idle(20);
        base = rise_cnt;
        send_frame(8'hC3, 1'b1);
        idle(4);
        sample();
        chk("c3_rises", rise_cnt - base, 1);
        chk("c3_data",  rx_data, 8'hC3);
        chk("c3_ovr",   overrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
